// File: rtl/xor_stim_sequencer.sv
// Exhaustive 4-bit stimulus sequencer for the four-input XOR gate block.
// Sweeps a 4-bit pattern onto a..d, holding each pattern for STEP_DIV cycles,
// for SWEEPS full sweeps, with start/pause/stop control and a registered
// expected-parity bit for the downstream compare stage.
// Optional build macro: GRAY_SEQ_EN -- present the pattern in Gray code
// instead of plain binary (control and timing unchanged).
module xor_stim_sequencer #(
    parameter int unsigned STEP_DIV = 4,
    parameter int unsigned SWEEPS   = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic pause,
    input  logic stop,
    output logic a,
    output logic b,
    output logic c,
    output logic d,
    output logic vld,
    output logic stp,
    output logic exp_par,
    output logic busy,
    output logic done
);

    localparam int unsigned CW = 8;
    localparam logic [CW-1:0] DIV_LAST = CW'(STEP_DIV - 1);
    localparam logic [CW-1:0] SWP_LAST = CW'(SWEEPS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        r_state;
    logic [3:0]    r_pat;
    logic [CW-1:0] r_div;
    logic [CW-1:0] r_swp;

    logic          w_div_last;
    logic          w_terminal;
    logic [3:0]    w_pat_nxt;
    logic [CW-1:0] w_div_nxt;
    logic [CW-1:0] w_swp_nxt;
    logic [3:0]    w_enc_nxt;
    logic [3:0]    w_enc_cur;

    // Map the pattern counter onto the a..d outputs
    function automatic logic [3:0] encode(input logic [3:0] p);
`ifdef GRAY_SEQ_EN
        return p ^ (p >> 1);
`else
        return p;
`endif
    endfunction

    // Next-step counter values used by both RUN advance and pause entry
    assign w_div_last = (r_div == DIV_LAST);
    assign w_terminal = w_div_last && (r_pat == 4'd15) && (r_swp == SWP_LAST);
    assign w_pat_nxt  = w_div_last ? r_pat + 4'd1 : r_pat;
    assign w_div_nxt  = w_div_last ? '0 : r_div + CW'(1);
    assign w_swp_nxt  = (w_div_last && (r_pat == 4'd15)) ? r_swp + CW'(1) : r_swp;
    assign w_enc_nxt  = encode(w_pat_nxt);
    assign w_enc_cur  = encode(r_pat);

    // Control FSM, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_pat        <= '0;
            r_div        <= '0;
            r_swp        <= '0;
            {a, b, c, d} <= 4'd0;
            vld          <= 1'b0;
            stp          <= 1'b0;
            exp_par      <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state      <= S_RUN;
                        r_pat        <= '0;
                        r_div        <= '0;
                        r_swp        <= '0;
                        {a, b, c, d} <= encode(4'd0);
                        exp_par      <= ^encode(4'd0);
                        vld          <= 1'b1;
                        stp          <= 1'b1;
                        busy         <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        r_state      <= S_IDLE;
                        r_pat        <= '0;
                        r_div        <= '0;
                        r_swp        <= '0;
                        {a, b, c, d} <= 4'd0;
                        exp_par      <= 1'b0;
                        vld          <= 1'b0;
                        stp          <= 1'b0;
                        busy         <= 1'b0;
                    end else if (pause) begin
                        // The cycle that sees pause still counts, except the
                        // terminal one, which is replayed after resume.
                        r_state <= S_PAUSE;
                        vld     <= 1'b0;
                        stp     <= 1'b0;
                        if (!w_terminal) begin
                            r_pat <= w_pat_nxt;
                            r_div <= w_div_nxt;
                            r_swp <= w_swp_nxt;
                        end
                    end else if (w_terminal) begin
                        r_state      <= S_DONE;
                        r_pat        <= '0;
                        r_div        <= '0;
                        r_swp        <= '0;
                        {a, b, c, d} <= 4'd0;
                        exp_par      <= 1'b0;
                        vld          <= 1'b0;
                        stp          <= 1'b0;
                        busy         <= 1'b0;
                        done         <= 1'b1;
                    end else begin
                        r_pat        <= w_pat_nxt;
                        r_div        <= w_div_nxt;
                        r_swp        <= w_swp_nxt;
                        {a, b, c, d} <= w_enc_nxt;
                        exp_par      <= ^w_enc_nxt;
                        stp          <= w_div_last;
                        vld          <= 1'b1;
                    end
                end
                S_PAUSE: begin
                    if (stop) begin
                        r_state      <= S_IDLE;
                        r_pat        <= '0;
                        r_div        <= '0;
                        r_swp        <= '0;
                        {a, b, c, d} <= 4'd0;
                        exp_par      <= 1'b0;
                        vld          <= 1'b0;
                        stp          <= 1'b0;
                        busy         <= 1'b0;
                    end else if (!pause) begin
                        r_state      <= S_RUN;
                        {a, b, c, d} <= w_enc_cur;
                        exp_par      <= ^w_enc_cur;
                        vld          <= 1'b1;
                        stp          <= 1'b0;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xor_stim_sequencer.sv
// Directed testbench for xor_stim_sequencer: default instance (STEP_DIV=4,
// SWEEPS=2) and a fast instance (STEP_DIV=1, SWEEPS=1).
// Observed bundle order: {a,b,c,d,vld,stp,exp_par,busy,done}.
module tb_xor_stim_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, start2, pause, stop;
    logic a, b, c, d, vld, stp, exp_par, busy, done;
    logic a2, b2, c2, d2, vld2, stp2, exp_par2, busy2, done2;
    logic [8:0] obs1, obs2;

    int n_tests = 0;
    int n_fail  = 0;

    assign obs1 = {a, b, c, d, vld, stp, exp_par, busy, done};
    assign obs2 = {a2, b2, c2, d2, vld2, stp2, exp_par2, busy2, done2};

    xor_stim_sequencer #(.STEP_DIV(4), .SWEEPS(2)) u_dut (
        .clk(clk), .rst(rst), .start(start), .pause(pause), .stop(stop),
        .a(a), .b(b), .c(c), .d(d), .vld(vld), .stp(stp),
        .exp_par(exp_par), .busy(busy), .done(done)
    );

    xor_stim_sequencer #(.STEP_DIV(1), .SWEEPS(1)) u_dut_fast (
        .clk(clk), .rst(rst), .start(start2), .pause(pause), .stop(stop),
        .a(a2), .b(b2), .c(c2), .d(d2), .vld(vld2), .stp(stp2),
        .exp_par(exp_par2), .busy(busy2), .done(done2)
    );

    // Expected a..d for a given pattern index
    function automatic logic [3:0] enc(input logic [3:0] p);
`ifdef GRAY_SEQ_EN
        return p ^ (p >> 1);
`else
        return p;
`endif
    endfunction

    // Held-pattern frame: a..d from p, with vld/stp as given, busy=1
    function automatic logic [8:0] frame(input logic [3:0] p, input logic v, input logic s);
        logic [3:0] e;
        e = enc(p);
        return {e, v, s, ^e, 1'b1, 1'b0};
    endfunction

    // Default instance, uninterrupted run, RUN cycle m (1-based after start edge)
    function automatic logic [8:0] exp_run(input int m);
        logic [3:0] p;
        if (m >= 1 && m <= 128) begin
            p = 4'(((m - 1) / 4) % 16);
            return frame(p, 1'b1, ((m - 1) % 4) == 0);
        end
        if (m == 129) return 9'b0_0000_0001;
        return 9'd0;
    endfunction

    // Fast instance, uninterrupted run
    function automatic logic [8:0] exp_fast(input int m);
        if (m >= 1 && m <= 16) return frame(4'(m - 1), 1'b1, 1'b1);
        if (m == 17) return 9'b0_0000_0001;
        return 9'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; start2 = 1'b0; pause = 1'b0; stop = 1'b0;
        repeat (3) tick();
        n_tests++;
        if (obs1 !== 9'd0 || obs2 !== 9'd0) begin
            n_fail++;
            $display("FAIL reset: got %b / %b, want 0", obs1, obs2);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_full_run();
        logic [8:0] ex;
        start = 1'b1; tick(); start = 1'b0;
        for (int cyc = 1; cyc <= 131; cyc++) begin
            start = (cyc == 129);
            ex = exp_run(cyc);
            n_tests++;
            if (obs1 !== ex) begin
                n_fail++;
                $display("FAIL full_run cyc %0d: got %b want %b", cyc, obs1, ex);
            end
            tick();
        end
        start = 1'b0;
    endtask

    task automatic test_pause();
        logic [8:0] ex;
        start = 1'b1; tick(); start = 1'b0;
        for (int cyc = 1; cyc <= 140; cyc++) begin
            pause = (cyc >= 7 && cyc <= 16);
            if (cyc <= 7)       ex = exp_run(cyc);
            else if (cyc <= 17) ex = frame(4'd1, 1'b0, 1'b0);
            else if (cyc == 18) ex = frame(4'd1, 1'b1, 1'b0);
            else                ex = exp_run(cyc - 10);
            n_tests++;
            if (obs1 !== ex) begin
                n_fail++;
                $display("FAIL pause cyc %0d: got %b want %b", cyc, obs1, ex);
            end
            tick();
        end
        pause = 1'b0;
    endtask

    task automatic test_stop();
        logic [8:0] ex;
        start = 1'b1; tick(); start = 1'b0;
        for (int cyc = 1; cyc <= 45; cyc++) begin
            stop = (cyc == 40);
            ex = (cyc <= 40) ? exp_run(cyc) : 9'd0;
            n_tests++;
            if (obs1 !== ex) begin
                n_fail++;
                $display("FAIL stop cyc %0d: got %b want %b", cyc, obs1, ex);
            end
            tick();
        end
        stop = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        for (int cyc = 1; cyc <= 130; cyc++) begin
            ex = exp_run(cyc);
            n_tests++;
            if (obs1 !== ex) begin
                n_fail++;
                $display("FAIL restart cyc %0d: got %b want %b", cyc, obs1, ex);
            end
            tick();
        end
    endtask

    task automatic test_stop_pause_start();
        logic [8:0] ex;
        start = 1'b1; tick(); start = 1'b0;
        for (int cyc = 1; cyc <= 24; cyc++) begin
            start = (cyc >= 3 && cyc <= 10);
            stop  = (cyc == 20);
            pause = (cyc >= 20 && cyc <= 22);
            ex = (cyc <= 20) ? exp_run(cyc) : 9'd0;
            n_tests++;
            if (obs1 !== ex) begin
                n_fail++;
                $display("FAIL stop_pause cyc %0d: got %b want %b", cyc, obs1, ex);
            end
            tick();
        end
        start = 1'b0; stop = 1'b0; pause = 1'b0;
    endtask

    task automatic test_reset_midrun();
        logic [8:0] ex;
        start = 1'b1; tick(); start = 1'b0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            rst = (cyc == 50);
            ex = (cyc <= 50) ? exp_run(cyc) : 9'd0;
            n_tests++;
            if (obs1 !== ex) begin
                n_fail++;
                $display("FAIL reset_midrun cyc %0d: got %b want %b", cyc, obs1, ex);
            end
            tick();
        end
        rst = 1'b0;
    endtask

    task automatic test_fast_run();
        logic [8:0] ex;
        start2 = 1'b1; tick(); start2 = 1'b0;
        for (int cyc = 1; cyc <= 18; cyc++) begin
            ex = exp_fast(cyc);
            n_tests++;
            if (obs2 !== ex) begin
                n_fail++;
                $display("FAIL fast_run cyc %0d: got %b want %b", cyc, obs2, ex);
            end
            tick();
        end
    endtask

    task automatic test_pause_terminal();
        logic [8:0] ex;
        start2 = 1'b1; tick(); start2 = 1'b0;
        for (int cyc = 1; cyc <= 22; cyc++) begin
            pause = (cyc >= 16 && cyc <= 18);
            if (cyc <= 16)      ex = exp_fast(cyc);
            else if (cyc <= 19) ex = frame(4'd15, 1'b0, 1'b0);
            else if (cyc == 20) ex = frame(4'd15, 1'b1, 1'b0);
            else if (cyc == 21) ex = 9'b0_0000_0001;
            else                ex = 9'd0;
            n_tests++;
            if (obs2 !== ex) begin
                n_fail++;
                $display("FAIL pause_terminal cyc %0d: got %b want %b", cyc, obs2, ex);
            end
            tick();
        end
        pause = 1'b0;
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_pause();
        test_stop();
        test_stop_pause_start();
        test_reset_midrun();
        test_fast_run();
        test_pause_terminal();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/xor_stim_sequencer.md
Name: xor_stim_sequencer

Overview:
Upstream stimulus stage for the four-input XOR gate block: drives its a, b, c, d inputs with an exhaustive, clock-synchronous 4-bit pattern sweep. Replaces free-running delay toggling with a started/paused/stoppable sequencer. Also provides a registered expected-parity bit and valid/step strobes, so the downstream compare stage can check the gate's outputs cycle by cycle.

Parameters:
STEP_DIV, 4, clock cycles each pattern is held; legal range 1..255.
SWEEPS, 2, full 16-pattern sweeps per run; legal range 1..255.

Ports:
clk  input  1  system clock; all state changes on its rising edge
rst  input  1  reset, synchronous and active-high
start  input  1  run request; sampled in IDLE only
pause  input  1  level; freezes the sequence while high
stop  input  1  abort; returns to IDLE
a  output  1  pattern bit 3, slowest toggling
b  output  1  pattern bit 2
c  output  1  pattern bit 1
d  output  1  pattern bit 0, fastest toggling
vld  output  1  pattern on a..d is live
stp  output  1  one-cycle pulse on the first cycle of each new pattern
exp_par  output  1  a^b^c^d of the current outputs
busy  output  1  high in RUN or PAUSE
done  output  1  one-cycle pulse at normal run completion

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (rst=1 at an edge): state=IDLE; a, b, c, d, vld, stp, exp_par, busy and done are all 0 after that edge; all counters are 0. Reset mid-run aborts immediately, with no done pulse.
- Internal state:
  - pat[3:0] binary pattern counter.
  - div counter, 0..STEP_DIV-1.
  - swp counter, 0..SWEEPS-1.
  - All outputs are registered.
- FSM states: IDLE, RUN, PAUSE, DONE.
- IDLE:
  - Outputs are 0.
  - start=1 at edge k -> RUN after edge k, with pat=0, div=0, swp=0, vld=1, stp=1, busy=1. Latency is 1 cycle.
  - stop and pause are ignored in IDLE.
- RUN:
  - div increments each cycle. When div=STEP_DIV-1: div clears, pat increments mod 16, and stp=1 for the next cycle.
  - When pat wraps from 15 to 0: swp increments.
  - Terminal condition is pat=15, div=STEP_DIV-1 and swp=SWEEPS-1. It moves to DONE on the next edge.
  - Nominal RUN length is 16*STEP_DIV*SWEEPS cycles.
- PAUSE:
  - pause=1 in RUN -> PAUSE on the next edge. pat, div and swp freeze; vld=0, stp=0; a..d hold their value; busy stays 1.
  - pause=0 -> return to RUN, resuming with the same div value. stp is not re-asserted.
- DONE: one cycle with done=1, busy=0, vld=0 and a..d=0; then IDLE unconditionally. A start in DONE is ignored.
- Priority in RUN/PAUSE: stop > pause > terminal. stop -> IDLE with no done pulse. start is ignored while busy.
- A pause asserted on the terminal cycle goes to PAUSE; done occurs after resume.
- STEP_DIV=1: the pattern advances every cycle and stp stays high throughout RUN.
- exp_par is registered and always consistent with the a..d values presented in the same cycle.

Optional Feature:
- Macro: GRAY_SEQ_EN.
- Defined: {a,b,c,d} = pat ^ (pat>>1), so exactly one output toggles per step, including the 15->0 wrap (1000->0000). exp_par is computed from the Gray outputs.
- Undefined: {a,b,c,d} = pat in plain binary. The control FSM and timing are identical in both builds.

Test Plan:
1. Default params; rst 3 cycles, then start pulse at edge 0 -> RUN cycles 1..128. {a,b,c,d} at RUN cycle n = ((n-1)/4) mod 16. stp on cycles 1, 5, 9, ... exp_par = popcount parity. done=1 on cycle 129; busy=0 from cycle 129.
2. Pause high for 10 cycles starting at RUN cycle 7 (pattern 1) -> a..d hold 0001, vld=0 during the pause. After release, pattern 2 appears 2 cycles later; done is delayed by exactly 10 cycles.
3. stop at RUN cycle 40 -> IDLE next edge; a..d=0, busy=0, no done pulse. A new start then restarts from pattern 0 with swp=0.
4. Simultaneous stop and pause in RUN -> IDLE, not PAUSE. start asserted during RUN has no effect on pattern or timing.
5. rst asserted at RUN cycle 50 -> all outputs 0 next edge, no done pulse. STEP_DIV=1, SWEEPS=1 run -> 16 consecutive patterns 0..15, stp high for all 16 cycles, done on cycle 17.
6. GRAY_SEQ_EN defined, STEP_DIV=1 -> output sequence 0000, 0001, 0011, 0010, ..., 1000, with one bit changing per cycle. exp_par alternates 0, 1, 0, 1, ...
